mic_reg_bank: RTL and testbench

- Register bank for the MIC datapath. It is the responder on both internal buses.
- Drives the B/A bus from the 4-bit source code consumed by the bus-A decoder.
- Latches the C bus into any subset of registers under a 9-bit write mask.
- Owns the MAR/MDR/PC/MBR memory port with a one-outstanding-request handshake.
- Sits between the control store/microsequencer and the ALU/shifter.

---
 rtl/mic_pkg.sv | 40 ++++
 rtl/mic_reg_bank_if.sv | 30 +++
 rtl/mic_mem_if.sv | 80 ++++++++
 rtl/mic_reg_bank.sv | 80 ++++++++
 tb/tb_mic_reg_bank.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mic_pkg.sv
// Shared types and constants for the MIC register bank: bus-A source codes,
// C-bus write-mask bit positions and the memory-port FSM states.
package mic_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 9;

  typedef enum logic [3:0] {
    B_H     = 4'd0,
    B_OPC   = 4'd1,
    B_TOS   = 4'd2,
    B_CPP   = 4'd3,
    B_LV    = 4'd4,
    B_SP    = 4'd5,
    B_MBR2U = 4'd6,
    B_MBR2S = 4'd7,
    B_MBRU  = 4'd8,
    B_MBRS  = 4'd9,
    B_MDR   = 4'd10,
    B_NONE  = 4'd11
  } b_sel_e;

  localparam int C_H   = 0;
  localparam int C_OPC = 1;
  localparam int C_TOS = 2;
  localparam int C_CPP = 3;
  localparam int C_LV  = 4;
  localparam int C_SP  = 5;
  localparam int C_PC  = 6;
  localparam int C_MDR = 7;
  localparam int C_MAR = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD    = 2'd1,
    ST_WR    = 2'd2,
    ST_FETCH = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mic_reg_bank_if.sv
// Datapath-side bus and memory port of the register bank; the bank is the
// slave, the microsequencer/memory side is the master.
interface mic_reg_bank_if #(parameter int DW = mic_pkg::DATA_W);
  logic [3:0]    b_sel;
  logic [DW-1:0] c_bus;
  logic [8:0]    c_wr;
  logic          mem_rd;
  logic          mem_wr;
  logic          mem_fetch;
  logic [DW-1:0] a_bus;
  logic [DW-1:0] h_out;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_req;
  logic          mem_we;
  logic          mem_is_fetch;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  modport slave (
    input  b_sel, c_bus, c_wr, mem_rd, mem_wr, mem_fetch, mem_ack, mem_rdata,
    output a_bus, h_out, mem_addr, mem_wdata, mem_req, mem_we, mem_is_fetch, busy
  );

  modport master (
    output b_sel, c_bus, c_wr, mem_rd, mem_wr, mem_fetch, mem_ack, mem_rdata,
    input  a_bus, h_out, mem_addr, mem_wdata, mem_req, mem_we, mem_is_fetch, busy
  );
endinterface

// File: rtl/mic_mem_if.sv
// Memory-port sequencer: one outstanding request, address/data captured at issue.
// state    | meaning
// IDLE     | no request; accepts wr > rd > fetch
// RD/WR    | word request at captured MAR pending until ack
// FETCH    | byte fetch at captured PC pending until ack
module mic_mem_if #(parameter int DW = mic_pkg::DATA_W) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_rd,
  input  logic          mem_wr,
  input  logic          mem_fetch,
  input  logic          mem_ack,
  input  logic [DW-1:0] mar,
  input  logic [DW-1:0] mdr,
  input  logic [DW-1:0] pc,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic          mem_is_fetch,
  output logic          busy,
  output logic          rd_done,
  output logic          fetch_done
);
  import mic_pkg::*;

  mem_state_e    state_q, state_d;
  logic [DW-1:0] addr_q, wdata_q;

  // Capture uses pre-edge MAR/MDR/PC, so same-cycle C-bus writes cannot leak in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE) begin
        if (mem_wr) begin
          addr_q  <= mar;
          wdata_q <= mdr;
        end else if (mem_rd) begin
          addr_q <= mar;
        end else if (mem_fetch) begin
          addr_q <= pc;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_done    = 1'b0;
    fetch_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_wr)         state_d = ST_WR;
        else if (mem_rd)    state_d = ST_RD;
        else if (mem_fetch) state_d = ST_FETCH;
      end
      ST_RD: if (mem_ack) begin
        rd_done = 1'b1;
        state_d = ST_IDLE;
      end
      ST_WR: if (mem_ack) state_d = ST_IDLE;
      ST_FETCH: if (mem_ack) begin
        fetch_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_req      = (state_q != ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign mem_we       = (state_q == ST_WR);
  assign mem_is_fetch = (state_q == ST_FETCH);
endmodule

// File: rtl/mic_reg_bank.sv
// MIC register bank: nine C-bus-writable registers, MBR/MBR2 fetch buffers,
// the combinational bus-A mux and the memory-port sequencer.
module mic_reg_bank #(
  parameter int                DATA_W  = mic_pkg::DATA_W,
  parameter logic [DATA_W-1:0] SP_INIT = 32'h0000_8000,
  parameter logic [DATA_W-1:0] LV_INIT = 32'h0000_4000
) (
  input logic           clk,
  input logic           reset,
  mic_reg_bank_if.slave bus
);
  import mic_pkg::*;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [7:0]        mbr;
  logic [15:0]       mbr2;
  logic              rd_done, fetch_done;
  logic [DATA_W-1:0] a_mux;

  // Read data is applied after the C-bus loop so memory wins on MDR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      regs[C_SP] <= SP_INIT;
      regs[C_LV] <= LV_INIT;
      mbr        <= '0;
      mbr2       <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (bus.c_wr[i]) regs[i] <= bus.c_bus;
      end
      if (rd_done) regs[C_MDR] <= bus.mem_rdata;
      if (fetch_done) begin
        mbr  <= bus.mem_rdata[7:0];
        mbr2 <= bus.mem_rdata[15:0];
      end
    end
  end

  always_comb begin
    a_mux = '0;
    case (b_sel_e'(bus.b_sel))
      B_H:     a_mux = regs[C_H];
      B_OPC:   a_mux = regs[C_OPC];
      B_TOS:   a_mux = regs[C_TOS];
      B_CPP:   a_mux = regs[C_CPP];
      B_LV:    a_mux = regs[C_LV];
      B_SP:    a_mux = regs[C_SP];
      B_MBR2U: a_mux = {{(DATA_W-16){1'b0}}, mbr2};
      B_MBR2S: a_mux = {{(DATA_W-16){mbr2[15]}}, mbr2};
      B_MBRU:  a_mux = {{(DATA_W-8){1'b0}}, mbr};
      B_MBRS:  a_mux = {{(DATA_W-8){mbr[7]}}, mbr};
      B_MDR:   a_mux = regs[C_MDR];
      default: a_mux = '0;
    endcase
  end

  assign bus.a_bus = a_mux;
  assign bus.h_out = regs[C_H];

  mic_mem_if #(.DW(DATA_W)) u_mem (
    .clk          (clk),
    .reset        (reset),
    .mem_rd       (bus.mem_rd),
    .mem_wr       (bus.mem_wr),
    .mem_fetch    (bus.mem_fetch),
    .mem_ack      (bus.mem_ack),
    .mar          (regs[C_MAR]),
    .mdr          (regs[C_MDR]),
    .pc           (regs[C_PC]),
    .mem_addr     (bus.mem_addr),
    .mem_wdata    (bus.mem_wdata),
    .mem_req      (bus.mem_req),
    .mem_we       (bus.mem_we),
    .mem_is_fetch (bus.mem_is_fetch),
    .busy         (bus.busy),
    .rd_done      (rd_done),
    .fetch_done   (fetch_done)
  );
endmodule

// File: tb/tb_mic_reg_bank.sv
// Directed bench for mic_reg_bank: vector table for C writes and bus-A decode,
// hand sequences for reset, fetch, read/write collisions and mid-request reset.
module tb_mic_reg_bank;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  mic_reg_bank_if bus ();

  mic_reg_bank dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] c_bus;
    logic [8:0]  c_wr;
    logic [3:0]  b_sel;
    logic [31:0] exp_a;
    logic [31:0] exp_h;
  } vec_t;

  vec_t vecs [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sel_check(input string name, input logic [3:0] sel, input logic [31:0] exp);
    bus.b_sel = sel;
    #1;
    check(name, bus.a_bus, exp);
  endtask

  initial begin
    int busy_cnt;

    vecs[0]  = '{32'hDEAD_BEEF, 9'b000010101, 4'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[1]  = '{32'h0,         9'b000000000, 4'd2,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[2]  = '{32'h0,         9'b000000000, 4'd4,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[3]  = '{32'h0,         9'b000000000, 4'd5,  32'h0000_8000, 32'hDEAD_BEEF};
    vecs[4]  = '{32'h0,         9'b000000000, 4'd1,  32'h0,         32'hDEAD_BEEF};
    vecs[5]  = '{32'h0,         9'b000000000, 4'd3,  32'h0,         32'hDEAD_BEEF};
    vecs[6]  = '{32'h1234_5678, 9'b000100000, 4'd5,  32'h1234_5678, 32'hDEAD_BEEF};
    vecs[7]  = '{32'h0,         9'b000000000, 4'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[8]  = '{32'hCAFE_0001, 9'b010000000, 4'd10, 32'hCAFE_0001, 32'hDEAD_BEEF};
    vecs[9]  = '{32'h0,         9'b000000000, 4'd11, 32'h0,         32'hDEAD_BEEF};
    vecs[10] = '{32'h0,         9'b000000000, 4'd15, 32'h0,         32'hDEAD_BEEF};
    vecs[11] = '{32'hFFFF_FFFF, 9'b111111111, 4'd1,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[12] = '{32'h0,         9'b000000000, 4'd6,  32'h0,         32'hFFFF_FFFF};

    reset         = 1'b1;
    bus.b_sel     = 4'd0;
    bus.c_bus     = '0;
    bus.c_wr      = '0;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_fetch = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    sel_check("reset_sp", 4'd5, 32'h0000_8000);
    sel_check("reset_lv", 4'd4, 32'h0000_4000);
    check("reset_busy", {31'b0, bus.busy}, 32'h0);
    check("reset_req", {31'b0, bus.mem_req}, 32'h0);

    for (int i = 0; i < 13; i++) begin
      bus.c_bus = vecs[i].c_bus;
      bus.c_wr  = vecs[i].c_wr;
      tick();
      bus.c_wr  = '0;
      bus.b_sel = vecs[i].b_sel;
      #1;
      check($sformatf("vec%0d_a_bus", i), bus.a_bus, vecs[i].exp_a);
      check($sformatf("vec%0d_h_out", i), bus.h_out, vecs[i].exp_h);
    end

    // Asynchronous reset mid-cycle, no clock edge in between.
    #1 reset = 1'b1;
    sel_check("async_reset_sp", 4'd5, 32'h0000_8000);
    sel_check("async_reset_lv", 4'd4, 32'h0000_4000);
    check("async_reset_h", bus.h_out, 32'h0);
    check("async_reset_addr", bus.mem_addr, 32'h0);
    #1 reset = 1'b0;
    tick();

    // Fetch with sign-extension readback.
    bus.c_bus = 32'h0000_0100;
    bus.c_wr  = 9'b001000000;
    tick();
    bus.c_wr      = '0;
    bus.mem_fetch = 1'b1;
    tick();
    bus.mem_fetch = 1'b0;
    check("fetch_req", {31'b0, bus.mem_req}, 32'h1);
    check("fetch_is_fetch", {31'b0, bus.mem_is_fetch}, 32'h1);
    check("fetch_we", {31'b0, bus.mem_we}, 32'h0);
    check("fetch_addr", bus.mem_addr, 32'h0000_0100);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0000_80F0;
    tick();
    bus.mem_ack = 1'b0;
    check("fetch_done_busy", {31'b0, bus.busy}, 32'h0);
    sel_check("mbr_sext", 4'd9, 32'hFFFF_FFF0);
    sel_check("mbr_zext", 4'd8, 32'h0000_00F0);
    sel_check("mbr2_sext", 4'd7, 32'hFFFF_80F0);
    sel_check("mbr2_zext", 4'd6, 32'h0000_80F0);

    // Read: MAR write in the issue cycle must not affect the address; ack collides with C write of MDR.
    bus.c_bus = 32'h10;
    bus.c_wr  = 9'b100000000;
    tick();
    bus.mem_rd = 1'b1;
    bus.c_bus  = 32'h99;
    tick();
    bus.mem_rd = 1'b0;
    bus.c_wr   = '0;
    check("rd_addr", bus.mem_addr, 32'h10);
    check("rd_busy", {31'b0, bus.busy}, 32'h1);
    check("rd_we", {31'b0, bus.mem_we}, 32'h0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1234;
    bus.c_wr      = 9'b010000000;
    bus.c_bus     = 32'h5555;
    tick();
    bus.mem_ack = 1'b0;
    bus.c_wr    = '0;
    check("rd_busy_one_cycle", {31'b0, bus.busy}, 32'h0);
    sel_check("rd_mdr_collision", 4'd10, 32'h1234);

    // Write with all commands asserted (write wins), MDR overwritten while pending.
    bus.c_bus = 32'hAA;
    bus.c_wr  = 9'b010000000;
    tick();
    bus.c_wr      = '0;
    bus.mem_wr    = 1'b1;
    bus.mem_rd    = 1'b1;
    bus.mem_fetch = 1'b1;
    tick();
    bus.mem_wr    = 1'b0;
    bus.mem_rd    = 1'b0;
    bus.mem_fetch = 1'b0;
    check("wr_we", {31'b0, bus.mem_we}, 32'h1);
    check("wr_is_fetch", {31'b0, bus.mem_is_fetch}, 32'h0);
    check("wr_addr", bus.mem_addr, 32'h99);
    busy_cnt = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (bus.busy) busy_cnt++;
      check($sformatf("wr_wdata_c%0d", cyc), bus.mem_wdata, 32'hAA);
      if (cyc == 0) begin
        bus.c_wr   = 9'b010000000;
        bus.c_bus  = 32'hBB;
        bus.mem_rd = 1'b1;
      end
      if (cyc == 2) bus.mem_ack = 1'b1;
      tick();
      bus.c_wr    = '0;
      bus.mem_rd  = 1'b0;
      bus.mem_ack = 1'b0;
    end
    check("wr_busy_cycles", busy_cnt, 32'd3);
    sel_check("wr_mdr_c_write", 4'd10, 32'hBB);

    // Ack while idle is ignored.
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h7777;
    tick();
    bus.mem_ack = 1'b0;
    sel_check("idle_ack_mdr", 4'd10, 32'hBB);
    check("idle_ack_busy", {31'b0, bus.busy}, 32'h0);

    // Reset mid-fetch, then a late ack.
    bus.c_bus = 32'h200;
    bus.c_wr  = 9'b001000000;
    tick();
    bus.c_wr      = '0;
    bus.mem_fetch = 1'b1;
    tick();
    bus.mem_fetch = 1'b0;
    check("rst_fetch_req_before", {31'b0, bus.mem_req}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("rst_fetch_req_drop", {31'b0, bus.mem_req}, 32'h0);
    check("rst_fetch_busy_drop", {31'b0, bus.busy}, 32'h0);
    #1 reset = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0000_00FF;
    tick();
    bus.mem_ack = 1'b0;
    sel_check("rst_fetch_mbr", 4'd8, 32'h0);
    check("rst_fetch_req_after", {31'b0, bus.mem_req}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
